// File: rtl/frame_streamer_if.sv
// Handshake and data bundle between the ADC capture buffer and its control/transmit neighbours.
interface frame_streamer_if #(
  parameter int DATA_WIDTH = 13,
  parameter int ADDR_WIDTH = 11
);
  logic [DATA_WIDTH-1:0] adc_data_in;
  logic                  start;
  logic [ADDR_WIDTH:0]   frame_len;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] frame;
  logic                  tx_valid;
  logic                  busy;
  logic                  done;

  modport master (
    output adc_data_in, start, frame_len, tx_ready,
    input  frame, tx_valid, busy, done
  );

  modport slave (
    input  adc_data_in, start, frame_len, tx_ready,
    output frame, tx_valid, busy, done
  );
endinterface

// File: rtl/frame_streamer.sv
// Capture-and-playback frame buffer: arm, settle, capture L ADC samples, replay them paced over valid/ready.
// Continuous re-capture (DONE back to WAIT) is enabled by defining FRAME_STREAMER_REPEAT_EN.
module frame_streamer #(
  parameter int DATA_WIDTH   = 13,
  parameter int ADDR_WIDTH   = 11,
  parameter int FRAME_LEN    = 2048,
  parameter int START_CYCLES = 1024,
  parameter int TX_DIV       = 16384
) (
  input  logic            adc_clk_out,
  input  logic            reset,
  frame_streamer_if.slave bus
);
  localparam int CNT_W  = ADDR_WIDTH + 1;
  localparam int WAIT_W = (START_CYCLES > 0) ? $clog2(START_CYCLES + 1) : 1;
  localparam int PACE_W = $clog2(TX_DIV + 1);

  localparam logic [CNT_W-1:0]  MAX_LEN     = CNT_W'(FRAME_LEN);
  localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'((START_CYCLES > 0) ? START_CYCLES - 1 : 0);
  localparam logic [PACE_W-1:0] PACE_LOAD   = PACE_W'(TX_DIV);
  // The accepting cycle already counts as the first cycle of the next pacing interval.
  localparam logic [PACE_W-1:0] PACE_RELOAD = PACE_W'(TX_DIV - 1);
  localparam bit                BACK_TO_BACK = (TX_DIV == 1);

`ifdef FRAME_STREAMER_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, WAIT, CAPTURE, SEND, DONE} state_t;
  localparam state_t ARM_STATE = (START_CYCLES == 0) ? CAPTURE : WAIT;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      len_q, len_eff, wr_addr, rd_addr;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [PACE_W-1:0]     pace_cnt;
  logic [DATA_WIDTH-1:0] ram [FRAME_LEN];
  logic [DATA_WIDTH-1:0] frame_p1;
  logic                  vld_p1;
  logic                  accept, last_word, present;

  always_comb begin
    state_d   = state_q;
    len_eff   = ((bus.frame_len == '0) || (bus.frame_len > MAX_LEN)) ? MAX_LEN : bus.frame_len;
    accept    = (state_q == SEND) && vld_p1 && bus.tx_ready;
    last_word = (rd_addr == len_q);
    present   = (state_q == SEND) &&
                ((!vld_p1 && (pace_cnt == PACE_W'(1))) || (BACK_TO_BACK && accept && !last_word));
    case (state_q)
      IDLE:    if (bus.start) state_d = ARM_STATE;
      WAIT:    if (wait_cnt == WAIT_LAST) state_d = CAPTURE;
      CAPTURE: if (wr_addr + CNT_W'(1) == len_q) state_d = SEND;
      SEND:    if (accept && last_word) state_d = DONE;
      DONE:    state_d = REPEAT ? ARM_STATE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge adc_clk_out) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Stage p0 -> RAM: one sample written per CAPTURE cycle.
  always_ff @(posedge adc_clk_out) begin
    if (reset && (state_q == CAPTURE)) ram[wr_addr[ADDR_WIDTH-1:0]] <= bus.adc_data_in;
  end

  // Stage RAM -> p1: the output register doubles as the RAM read register.
  always_ff @(posedge adc_clk_out) begin
    if (!reset) begin
      len_q    <= MAX_LEN;
      wait_cnt <= '0;
      wr_addr  <= '0;
      rd_addr  <= '0;
      pace_cnt <= PACE_LOAD;
      vld_p1   <= 1'b0;
      frame_p1 <= '0;
    end else begin
      if ((state_q == IDLE) && bus.start) len_q <= len_eff;
      wait_cnt <= (state_q == WAIT)    ? wait_cnt + WAIT_W'(1) : '0;
      wr_addr  <= (state_q == CAPTURE) ? wr_addr + CNT_W'(1)   : '0;
      if (state_q != SEND) begin
        rd_addr  <= '0;
        pace_cnt <= PACE_LOAD;
        vld_p1   <= 1'b0;
      end else begin
        if (present) begin
          frame_p1 <= ram[rd_addr[ADDR_WIDTH-1:0]];
          rd_addr  <= rd_addr + CNT_W'(1);
        end
        if (present)     vld_p1 <= 1'b1;
        else if (accept) vld_p1 <= 1'b0;
        if (accept)
          pace_cnt <= PACE_RELOAD;
        else if (!vld_p1 && (pace_cnt != PACE_W'(1)))
          pace_cnt <= pace_cnt - PACE_W'(1);
      end
    end
  end

  assign bus.frame    = frame_p1;
  assign bus.tx_valid = vld_p1;
  assign bus.busy     = (state_q == WAIT) || (state_q == CAPTURE) || (state_q == SEND) ||
                        (REPEAT && (state_q == DONE));
  assign bus.done     = (state_q == DONE);
endmodule

// File: tb/tb_frame_streamer.sv
// Bench for frame_streamer: random ADC samples, directed arm/length/back-pressure/reset scenarios
// checked against a timeline model derived from the start edge, settle time, length and pacing.
module tb_frame_streamer;
  localparam int DW     = 13;
  localparam int AW     = 3;
  localparam int FL     = 8;
  localparam int SC     = 4;
  localparam int SAMP_N = 4096;
`ifdef FRAME_STREAMER_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   edge_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  logic [DW-1:0] adc = '0;
  logic [DW-1:0] samp [SAMP_N];

  frame_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) aif ();
  frame_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bif ();

  assign aif.adc_data_in = adc;
  assign bif.adc_data_in = adc;

  frame_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_LEN(FL), .START_CYCLES(SC), .TX_DIV(3))
    dut_a (.adc_clk_out(clk), .reset(reset), .bus(aif));
  frame_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_LEN(FL), .START_CYCLES(SC), .TX_DIV(1))
    dut_b (.adc_clk_out(clk), .reset(reset), .bus(bif));

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    edge_cnt = edge_cnt + 1;
  end

  // New random sample for the next edge, remembered by edge number.
  initial forever begin
    @(negedge clk);
    adc = DW'($urandom_range(0, (1 << DW) - 1));
    samp[(edge_cnt + 1) % SAMP_N] = adc;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, edge_cnt, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_valid(input int w);
    return (w != 0) ? 32'(bif.tx_valid) : 32'(aif.tx_valid);
  endfunction
  function automatic logic [31:0] obs_frame(input int w);
    return (w != 0) ? 32'(bif.frame) : 32'(aif.frame);
  endfunction
  function automatic logic [31:0] obs_busy(input int w);
    return (w != 0) ? 32'(bif.busy) : 32'(aif.busy);
  endfunction
  function automatic logic [31:0] obs_done(input int w);
    return (w != 0) ? 32'(bif.done) : 32'(aif.done);
  endfunction

  function automatic int eff_len(input int req);
    return ((req == 0) || (req > FL)) ? FL : req;
  endfunction

  task automatic drive_ready(input int w, input logic v);
    if (w != 0) bif.tx_ready = v; else aif.tx_ready = v;
  endtask
  task automatic drive_start(input int w, input logic v);
    if (w != 0) bif.start = v; else aif.start = v;
  endtask

  // Start is sampled at edge s; afterwards frame_len is scrambled to prove it was latched.
  task automatic arm(input int w, input int req, output int s);
    if (w != 0) bif.frame_len = (AW + 1)'(req); else aif.frame_len = (AW + 1)'(req);
    drive_start(w, 1'b1);
    s = edge_cnt + 1;
    tick();
    drive_start(w, 1'b0);
    if (w != 0) bif.frame_len = (AW + 1)'($urandom_range(0, 15));
    else        aif.frame_len = (AW + 1)'($urandom_range(0, 15));
  endtask

  // Expected timeline: capture edges s+SC+1 .. s+SC+L, SEND entered at edge s+SC+L,
  // word 0 visible txd edges later, each later word txd cycles after the previous accept cycle.
  task automatic collect(input int w, input int s, input int len, input int txd,
                         input int stall_word, input int stall_len, input bit rand_rdy,
                         input bit spam, input int abort_word, output int done_edge);
    int k, next_vis, n, stall_left;
    bit ev, rdy, fin;
    k = 0;
    next_vis = s + SC + len + txd;
    stall_left = stall_len;
    done_edge = -1;
    fin = 1'b0;
    for (int c = 0; c < 600 && !fin; c++) begin
      n  = edge_cnt;
      ev = (k < len) && (n >= next_vis);
      check("tx_valid", obs_valid(w), 32'(ev));
      if (ev) check("frame", obs_frame(w), 32'(samp[(s + SC + 1 + k) % SAMP_N]));
      check("busy", obs_busy(w), 32'(REP || (done_edge < 0) || (n < done_edge)));
      check("done", obs_done(w), 32'(n == done_edge));
      if ((done_edge >= 0) && (n > done_edge)) begin
        fin = 1'b1;
      end else if (ev && (k == abort_word)) begin
        drive_ready(w, 1'b0);
        drive_start(w, 1'b0);
        reset = 1'b0;
        tick();
        check("abort_valid", obs_valid(w), 0);
        check("abort_busy", obs_busy(w), 0);
        check("abort_frame", obs_frame(w), 0);
        check("abort_done", obs_done(w), 0);
        reset = 1'b1;
        drive_ready(w, 1'b1);
        tick();
        check("post_abort_done", obs_done(w), 0);
        check("post_abort_busy", obs_busy(w), 0);
        fin = 1'b1;
      end else begin
        rdy = 1'b1;
        if (rand_rdy) rdy = 1'($urandom_range(0, 1));
        if (ev && (k == stall_word) && (stall_left > 0)) begin
          rdy = 1'b0;
          stall_left--;
        end
        drive_ready(w, rdy);
        drive_start(w, (spam && (done_edge < 0)) ? 1'($urandom_range(0, 1)) : 1'b0);
        if (ev && rdy) begin
          k++;
          if (k == len) done_edge = n + 1;
          else          next_vis = n + txd;
        end
        tick();
      end
    end
    check("frame_complete", 32'(fin), 1);
    drive_ready(w, 1'b1);
    drive_start(w, 1'b0);
  endtask

  task automatic settle(input int w);
    if (REP) begin
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      check("rep_reset_busy", obs_busy(w), 0);
    end else begin
      repeat (4) begin
        check("idle_valid", obs_valid(w), 0);
        check("idle_busy", obs_busy(w), 0);
        check("idle_done", obs_done(w), 0);
        tick();
      end
    end
  endtask

  initial begin
    int s, de, req;
    aif.start = 1'b0; aif.frame_len = '0; aif.tx_ready = 1'b1;
    bif.start = 1'b0; bif.frame_len = '0; bif.tx_ready = 1'b1;
    repeat (3) tick();
    check("rst_frame", obs_frame(0), 0);
    check("rst_valid", obs_valid(0), 0);
    check("rst_busy", obs_busy(0), 0);
    check("rst_done", obs_done(0), 0);
    check("rst_valid_b", obs_valid(1), 0);
    check("rst_busy_b", obs_busy(1), 0);
    reset = 1'b1;
    tick();
    check("idle_after_rst", obs_busy(0), 0);

    // Full frame, frame_len=0 selects FRAME_LEN.
    arm(0, 0, s);
    collect(0, s, FL, 3, -1, 0, 1'b0, 1'b0, -1, de);
    settle(0);

    // Short frame while start is hammered during the transfer.
    arm(0, 3, s);
    collect(0, s, 3, 3, -1, 0, 1'b0, 1'b1, -1, de);
    settle(0);

    // Oversize length clamps to FRAME_LEN; word 4 held off for 10 cycles.
    arm(0, 12, s);
    collect(0, s, FL, 3, 4, 10, 1'b0, 1'b0, -1, de);
    settle(0);

    // Random length with random back-pressure.
    req = $urandom_range(1, FL);
    arm(0, req, s);
    collect(0, s, eff_len(req), 3, -1, 0, 1'b1, 1'b0, -1, de);
    settle(0);

    // Reset while word 2 is offered, then a clean full frame.
    arm(0, 0, s);
    collect(0, s, FL, 3, -1, 0, 1'b0, 1'b0, 2, de);
    arm(0, 0, s);
    collect(0, s, FL, 3, -1, 0, 1'b0, 1'b0, -1, de);
    settle(0);

    // Unpaced instance: eight consecutive valid cycles.
    arm(1, 0, s);
    collect(1, s, FL, 1, -1, 0, 1'b0, 1'b1, -1, de);
    settle(1);

    // Continuous mode: two more frames follow without a new start.
    if (REP) begin
      arm(0, 5, s);
      collect(0, s, 5, 3, -1, 0, 1'b0, 1'b1, -1, de);
      collect(0, de + 1, 5, 3, -1, 0, 1'b0, 1'b1, -1, de);
      collect(0, de + 1, 5, 3, -1, 0, 1'b0, 1'b0, -1, de);
      settle(0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
